fetch_unit: RTL

Instruction-fetch front end; the producer side of the IF/ID pipeline register. It owns the PC and runs a single-outstanding request/response handshake to instruction memory. It presents instr_F / PC_F / PCP4_F to IF/ID, honours stall_F and execute-stage redirects, and raises fetch_busy so the hazard unit can hold or bubble the pipeline while fetch is starved.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_buffer.sv | 53 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    REQ  = 1'b0,
    RESP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry fetch buffer between the imem response and IF/ID.
// Flush beats refill, and refill beats consume.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(riscv_pkg::NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_consume,
  input  logic [WIDTH-1:0] i_instr,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pcp4
);

  logic             r_empty;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pcp4;

  // The instruction register holds the bubble word while empty; pc/pcp4 keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_empty <= 1'b1;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pcp4  <= '0;
    end else if (i_flush) begin
      r_empty <= 1'b1;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_empty <= 1'b0;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pcp4  <= i_pc + WIDTH'(4);
    end else if (i_consume) begin
      r_empty <= 1'b1;
      r_instr <= NOP_INSTR;
    end
  end

  assign o_empty = r_empty;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pcp4  = r_pcp4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and runs a single-outstanding
// request/response handshake to imem, feeding a one-entry buffer to IF/ID.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(riscv_pkg::NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_F,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_F,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] PCP4_F,
  output logic             fetch_busy
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] r_req_pc;
  logic [WIDTH-1:0] w_req_pc_nxt;
  logic             r_kill;
  logic             w_kill_nxt;
  logic             w_req;
  logic             w_load;
  logic             w_buf_empty;
  logic             w_consume;

  assign w_consume = !w_buf_empty && !stall_F;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_kill   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_kill   <= w_kill_nxt;
    end
  end

  // A request only goes out when the buffer is free by the next edge, so a response is never refused.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_kill_nxt   = r_kill;
    w_req        = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      REQ: begin
        w_req = rst_n && (w_buf_empty || w_consume);
        if (w_req && imem_gnt) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + WIDTH'(4);
          w_state_nxt  = RESP;
          if (redirect) w_kill_nxt = 1'b1;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          w_load      = !r_kill && !redirect;
          w_kill_nxt  = 1'b0;
          w_state_nxt = REQ;
        end else if (redirect) begin
          w_kill_nxt = 1'b1;
        end
      end
      default: w_state_nxt = REQ;
    endcase
    if (redirect) w_pc_nxt = redirect_pc;
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign fetch_busy = w_buf_empty;

  fetch_buffer #(
    .WIDTH     (WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (redirect),
    .i_load    (w_load),
    .i_consume (w_consume),
    .i_instr   (imem_rdata),
    .i_pc      (r_req_pc),
    .o_empty   (w_buf_empty),
    .o_instr   (instr_F),
    .o_pc      (PC_F),
    .o_pcp4    (PCP4_F)
  );

endmodule
